// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLBP/TLBR/TLBWI sequencer between write-back, CP0 and the TLB array.
// Takes one op at a time, waits out pending MTC0 writes, drives the TLB port, then reports to CP0.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  input  logic [31:0]     op_pc,
  input  logic            cp0_wr_pending,
  input  logic [18:0]     entryhi_vpn2,
  input  logic [7:0]      entryhi_asid,
  input  logic [IDXW-1:0] index_index,
  output logic [18:0]     s_vpn2,
  output logic [7:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  output logic [IDXW-1:0] r_index,
  input  logic [31:0]     r_entryhi,
  input  logic [31:0]     r_entrylo0,
  input  logic [31:0]     r_entrylo1,
  output logic            tlb_we,
  output logic [IDXW-1:0] w_index,
  output logic            tlbp_we,
  output logic            tlbr_we,
  output logic [31:0]     index,
  output logic [31:0]     entryhi,
  output logic [31:0]     entrylo0,
  output logic [31:0]     entrylo1,
  output logic            flush,
  output logic [31:0]     flush_pc,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXEC, S_COMMIT, S_FLUSH} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_TLBP  = 2'b01;
  localparam logic [1:0] OP_TLBR  = 2'b10;
  localparam logic [1:0] OP_TLBWI = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_code_q, op_code_d;
  logic [31:0] op_pc_q, op_pc_d;
  logic [31:0] index_q, index_d;
  logic [31:0] entryhi_q, entryhi_d;
  logic [31:0] entrylo0_q, entrylo0_d;
  logic [31:0] entrylo1_q, entrylo1_d;

  logic in_exec;
  logic in_commit;

  always_comb begin
    state_d    = state_q;
    op_code_d  = op_code_q;
    op_pc_d    = op_pc_q;
    index_d    = index_q;
    entryhi_d  = entryhi_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_code_d = op_code;
          op_pc_d   = op_pc;
          if (op_code != OP_NOP) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cp0_wr_pending) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_COMMIT;
        if (op_code_q == OP_TLBP) begin
          index_d = {~s_found, {(31-IDXW){1'b0}}, (s_found ? s_index : {IDXW{1'b0}})};
        end else if (op_code_q == OP_TLBR) begin
          entryhi_d  = r_entryhi;
          entrylo0_d = r_entrylo0;
          entrylo1_d = r_entrylo1;
        end
      end
      S_COMMIT: begin
        state_d = (op_code_q == OP_TLBP) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_code_q  <= OP_NOP;
      op_pc_q    <= 32'd0;
      index_q    <= 32'd0;
      entryhi_q  <= 32'd0;
      entrylo0_q <= 32'd0;
      entrylo1_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_code_q  <= op_code_d;
      op_pc_q    <= op_pc_d;
      index_q    <= index_d;
      entryhi_q  <= entryhi_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
    end
  end

  assign in_exec   = (state_q == S_EXEC);
  assign in_commit = (state_q == S_COMMIT);

  assign s_vpn2  = (in_exec && op_code_q == OP_TLBP)  ? entryhi_vpn2 : 19'd0;
  assign s_asid  = (in_exec && op_code_q == OP_TLBP)  ? entryhi_asid : 8'd0;
  assign r_index = (in_exec && op_code_q == OP_TLBR)  ? index_index  : {IDXW{1'b0}};
  assign w_index = (in_exec && op_code_q == OP_TLBWI) ? index_index  : {IDXW{1'b0}};
  assign tlb_we  = in_exec && (op_code_q == OP_TLBWI);

  // CP0-facing pulses are suppressed while reset is held so a reset in COMMIT/FLUSH emits nothing.
  assign tlbp_we  = in_commit && (op_code_q == OP_TLBP) && !reset;
  assign tlbr_we  = in_commit && (op_code_q == OP_TLBR) && !reset;
  assign flush    = (state_q == S_FLUSH) && !reset;
  assign flush_pc = flush ? (op_pc_q + 32'd4) : 32'd0;

  assign index    = index_q;
  assign entryhi  = entryhi_q;
  assign entrylo0 = entrylo0_q;
  assign entrylo1 = entrylo1_q;

  assign op_ready = (state_q == S_IDLE);
  assign busy     = ~op_ready;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - self-checking bench for tlb_op_ctrl with a behavioural TLB and CP0 model.
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_code;
  logic [31:0]     op_pc;
  logic            cp0_wr_pending;
  logic [18:0]     entryhi_vpn2;
  logic [7:0]      entryhi_asid;
  logic [IDXW-1:0] index_index;
  logic [18:0]     s_vpn2;
  logic [7:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [IDXW-1:0] r_index;
  logic [31:0]     r_entryhi, r_entrylo0, r_entrylo1;
  logic            tlb_we;
  logic [IDXW-1:0] w_index;
  logic            tlbp_we, tlbr_we;
  logic [31:0]     index, entryhi, entrylo0, entrylo1;
  logic            flush;
  logic [31:0]     flush_pc;
  logic            busy;

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_pc(op_pc), .cp0_wr_pending(cp0_wr_pending), .entryhi_vpn2(entryhi_vpn2),
    .entryhi_asid(entryhi_asid), .index_index(index_index), .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_entryhi(r_entryhi),
    .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1), .tlb_we(tlb_we), .w_index(w_index),
    .tlbp_we(tlbp_we), .tlbr_we(tlbr_we), .index(index), .entryhi(entryhi),
    .entrylo0(entrylo0), .entrylo1(entrylo1), .flush(flush), .flush_pc(flush_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural TLB array: lowest-numbered matching entry wins a search.
  logic [31:0] tlb_hi  [TLBNUM];
  logic [31:0] tlb_lo0 [TLBNUM];
  logic [31:0] tlb_lo1 [TLBNUM];
  logic            pre_en;
  logic [IDXW-1:0] pre_idx;
  logic [31:0]     pre_hi, pre_lo0, pre_lo1;
  logic [31:0]     cp0_lo0, cp0_lo1;

  always @(posedge clk) begin
    if (pre_en) begin
      tlb_hi[pre_idx]  <= pre_hi;
      tlb_lo0[pre_idx] <= pre_lo0;
      tlb_lo1[pre_idx] <= pre_lo1;
    end else if (tlb_we) begin
      tlb_hi[w_index]  <= {entryhi_vpn2, 5'b0, entryhi_asid};
      tlb_lo0[w_index] <= cp0_lo0;
      tlb_lo1[w_index] <= cp0_lo1;
    end
  end

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tlb_hi[i][31:13] == s_vpn2 && tlb_hi[i][7:0] == s_asid) begin
        s_found = 1'b1;
        s_index = i[IDXW-1:0];
      end
    end
  end

  assign r_entryhi  = tlb_hi[r_index];
  assign r_entrylo0 = tlb_lo0[r_index];
  assign r_entrylo1 = tlb_lo1[r_index];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_index, exp_hi, exp_lo0, exp_lo1;

  // Per-cycle observations of one op; slot k is cycle T+k after the accept edge T.
  logic [5:0]      obs_ctl [16];
  logic [31:0]     obs_fpc [16];
  logic [IDXW-1:0] obs_rix [16];
  logic [IDXW-1:0] obs_wix [16];
  logic [18:0]     obs_sv  [16];
  logic [7:0]      obs_sa  [16];

  function automatic logic [31:0] model_tlbp(input logic [18:0] v, input logic [7:0] a);
    for (int i = 0; i < TLBNUM; i++)
      if (tlb_hi[i][31:13] == v && tlb_hi[i][7:0] == a) return 32'(i);
    return 32'h8000_0000;
  endfunction

  task automatic set_entry(input logic [IDXW-1:0] i, input logic [31:0] hi,
                           input logic [31:0] lo0, input logic [31:0] lo1);
    pre_en = 1'b1; pre_idx = i; pre_hi = hi; pre_lo0 = lo0; pre_lo1 = lo1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Presents one op, keeps op_valid high with junk during the op, and records every cycle.
  task automatic run_op(input logic [1:0] code, input logic [31:0] pc, input int pend,
                        input logic [18:0] vpn, input logic [7:0] asid, input logic [IDXW-1:0] idx);
    int exec_k, ready_k;
    exec_k  = pend + 2;
    ready_k = (code == 2'b01) ? exec_k + 2 : exec_k + 3;
    op_valid = 1'b1; op_code = code; op_pc = pc; cp0_wr_pending = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= ready_k; k++) begin
      op_valid = (k < ready_k);
      op_code  = 2'($urandom);
      op_pc    = $urandom;
      cp0_wr_pending = (k <= pend);
      if (k < exec_k) begin
        entryhi_vpn2 = 19'($urandom); entryhi_asid = 8'($urandom); index_index = IDXW'($urandom);
      end else begin
        entryhi_vpn2 = vpn; entryhi_asid = asid; index_index = idx;
      end
      @(negedge clk);
      obs_ctl[k] = {tlb_we, tlbp_we, tlbr_we, flush, op_ready, busy};
      obs_fpc[k] = flush_pc; obs_rix[k] = r_index; obs_wix[k] = w_index;
      obs_sv[k]  = s_vpn2;   obs_sa[k]  = s_asid;
      if (k < ready_k) begin
        @(posedge clk); #1;
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tlb_we, tlbp_we, tlbr_we, flush, op_ready, busy} !== 6'b000010) begin
      errors++; $display("FAIL reset_ctl got %b exp 000010", {tlb_we, tlbp_we, tlbr_we, flush, op_ready, busy});
    end
    checks++;
    if ({index, entryhi, entrylo0, entrylo1, flush_pc} !== 160'd0) begin
      errors++; $display("FAIL reset_regs got %h %h %h %h %h exp all 0", index, entryhi, entrylo0, entrylo1, flush_pc);
    end
    checks++;
    if ({s_vpn2, s_asid, r_index, w_index} !== '0) begin
      errors++; $display("FAIL reset_ports got %h %h %h %h exp 0", s_vpn2, s_asid, r_index, w_index);
    end
  endtask

  task automatic test_tlbp_hit();
    set_entry(4'd7, {19'h12345, 5'b0, 8'h5A}, 32'h11, 32'h22);
    run_op(2'b01, 32'h0040_0100, 0, 19'h12345, 8'h5A, 4'd2);
    checks++;
    if ({obs_sv[2], obs_sa[2]} !== {19'h12345, 8'h5A}) begin
      errors++; $display("FAIL tlbp_hit_search got %h/%h exp 12345/5a", obs_sv[2], obs_sa[2]);
    end
    checks++;
    if ({obs_ctl[1], obs_ctl[2], obs_ctl[3], obs_ctl[4]} !== {6'b000001, 6'b000001, 6'b010001, 6'b000010}) begin
      errors++; $display("FAIL tlbp_hit_timeline got %b %b %b %b exp 000001 000001 010001 000010",
                         obs_ctl[1], obs_ctl[2], obs_ctl[3], obs_ctl[4]);
    end
    exp_index = 32'h0000_0007;
    checks++;
    if (index !== exp_index) begin
      errors++; $display("FAIL tlbp_hit_index got %h exp %h", index, exp_index);
    end
  endtask

  task automatic test_tlbp_miss();
    run_op(2'b01, 32'h0040_0200, 0, 19'h7FFFF, 8'h00, 4'd0);
    exp_index = 32'h8000_0000;
    checks++;
    if (obs_ctl[3] !== 6'b010001) begin
      errors++; $display("FAIL tlbp_miss_pulse got %b exp 010001", obs_ctl[3]);
    end
    checks++;
    if (index !== exp_index) begin
      errors++; $display("FAIL tlbp_miss_index got %h exp %h", index, exp_index);
    end
  endtask

  task automatic test_tlbr();
    set_entry(4'd3, 32'hAAAA_A05A, 32'h0000_1F47, 32'h0000_2F07);
    run_op(2'b10, 32'h8000_1000, 0, 19'h0, 8'h0, 4'd3);
    exp_hi = 32'hAAAA_A05A; exp_lo0 = 32'h0000_1F47; exp_lo1 = 32'h0000_2F07;
    checks++;
    if (obs_rix[2] !== 4'd3) begin
      errors++; $display("FAIL tlbr_rindex got %0d exp 3", obs_rix[2]);
    end
    checks++;
    if ({obs_ctl[3], obs_ctl[4], obs_ctl[5]} !== {6'b001001, 6'b000101, 6'b000010}) begin
      errors++; $display("FAIL tlbr_timeline got %b %b %b exp 001001 000101 000010", obs_ctl[3], obs_ctl[4], obs_ctl[5]);
    end
    checks++;
    if (obs_fpc[4] !== 32'h8000_1004) begin
      errors++; $display("FAIL tlbr_flush_pc got %h exp 80001004", obs_fpc[4]);
    end
    checks++;
    if ({entryhi, entrylo0, entrylo1, index} !== {exp_hi, exp_lo0, exp_lo1, exp_index}) begin
      errors++; $display("FAIL tlbr_data got %h %h %h %h exp %h %h %h %h", entryhi, entrylo0, entrylo1, index,
                         exp_hi, exp_lo0, exp_lo1, exp_index);
    end
  endtask

  task automatic test_tlbwi();
    cp0_lo0 = 32'h0000_3A47; cp0_lo1 = 32'h0000_3B07;
    run_op(2'b11, 32'hFFFF_FFFC, 0, 19'h2_4680, 8'h33, 4'd15);
    checks++;
    if ({obs_ctl[1], obs_ctl[2], obs_ctl[3], obs_ctl[4], obs_ctl[5]}
        !== {6'b000001, 6'b100001, 6'b000001, 6'b000101, 6'b000010}) begin
      errors++; $display("FAIL tlbwi_timeline got %b %b %b %b %b exp 000001 100001 000001 000101 000010",
                         obs_ctl[1], obs_ctl[2], obs_ctl[3], obs_ctl[4], obs_ctl[5]);
    end
    checks++;
    if (obs_wix[2] !== 4'd15) begin
      errors++; $display("FAIL tlbwi_windex got %0d exp 15", obs_wix[2]);
    end
    checks++;
    if (obs_fpc[4] !== 32'h0000_0000) begin
      errors++; $display("FAIL tlbwi_flush_pc_wrap got %h exp 00000000", obs_fpc[4]);
    end
    checks++;
    if (tlb_hi[15] !== {19'h2_4680, 5'b0, 8'h33}) begin
      errors++; $display("FAIL tlbwi_written got %h exp %h", tlb_hi[15], {19'h2_4680, 5'b0, 8'h33});
    end
  endtask

  task automatic test_mtc0_hazard();
    set_entry(4'd9, {19'h0_BEEF, 5'b0, 8'hC3}, 32'h0, 32'h0);
    run_op(2'b01, 32'h0000_4000, 3, 19'h0_BEEF, 8'hC3, 4'd1);
    checks++;
    if ({obs_ctl[4], obs_ctl[5], obs_ctl[6], obs_ctl[7]} !== {6'b000001, 6'b000001, 6'b010001, 6'b000010}) begin
      errors++; $display("FAIL hazard_timeline got %b %b %b %b exp 000001 000001 010001 000010",
                         obs_ctl[4], obs_ctl[5], obs_ctl[6], obs_ctl[7]);
    end
    checks++;
    if ({obs_sv[4], obs_sv[5], obs_sa[5]} !== {19'h0, 19'h0_BEEF, 8'hC3}) begin
      errors++; $display("FAIL hazard_search got %h %h %h exp 0 0beef c3", obs_sv[4], obs_sv[5], obs_sa[5]);
    end
    exp_index = 32'h0000_0009;
    checks++;
    if (index !== exp_index) begin
      errors++; $display("FAIL hazard_index got %h exp %h", index, exp_index);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] code; logic [31:0] pc; int pend, exec_k, ready_k;
    logic [18:0] vpn; logic [7:0] asid; logic [IDXW-1:0] idx; int j;
    logic [5:0] ectl; logic [IDXW-1:0] erix, ewix; logic [18:0] esv; logic [7:0] esa;
    for (int n = 0; n < 40; n++) begin
      code = 2'($urandom_range(0, 3));
      if (code == 2'b00) begin
        op_valid = 1'b1; op_code = 2'b00; op_pc = $urandom;
        @(posedge clk); #1; op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({op_ready, busy} !== 2'b10) begin
          errors++; $display("FAIL b2b_noop[%0d] got %b exp 10", n, {op_ready, busy});
        end
        continue;
      end
      pend = $urandom_range(0, 3); pc = $urandom; idx = IDXW'($urandom);
      j = $urandom_range(0, TLBNUM - 1);
      if ($urandom_range(0, 1) == 1) begin
        vpn = tlb_hi[j][31:13]; asid = tlb_hi[j][7:0];
      end else begin
        vpn = 19'($urandom); asid = 8'($urandom);
      end
      cp0_lo0 = $urandom; cp0_lo1 = $urandom;
      if (code == 2'b01) exp_index = model_tlbp(vpn, asid);
      if (code == 2'b10) begin exp_hi = tlb_hi[idx]; exp_lo0 = tlb_lo0[idx]; exp_lo1 = tlb_lo1[idx]; end
      exec_k  = pend + 2;
      ready_k = (code == 2'b01) ? exec_k + 2 : exec_k + 3;
      run_op(code, pc, pend, vpn, asid, idx);
      for (int k = 1; k <= ready_k; k++) begin
        ectl = {code == 2'b11 && k == exec_k, code == 2'b01 && k == exec_k + 1,
                code == 2'b10 && k == exec_k + 1, code != 2'b01 && k == exec_k + 2,
                k == ready_k, k != ready_k};
        checks++;
        if (obs_ctl[k] !== ectl || (ectl[2] && obs_fpc[k] !== pc + 32'd4)) begin
          errors++; $display("FAIL b2b_ctl[%0d] op %0d cyc %0d got %b/%h exp %b/%h", n, code, k,
                             obs_ctl[k], obs_fpc[k], ectl, pc + 32'd4);
        end
        esv  = (code == 2'b01 && k == exec_k) ? vpn  : 19'd0;
        esa  = (code == 2'b01 && k == exec_k) ? asid : 8'd0;
        erix = (code == 2'b10 && k == exec_k) ? idx  : '0;
        ewix = (code == 2'b11 && k == exec_k) ? idx  : '0;
        checks++;
        if ({obs_sv[k], obs_sa[k], obs_rix[k], obs_wix[k]} !== {esv, esa, erix, ewix}) begin
          errors++; $display("FAIL b2b_ports[%0d] cyc %0d got %h %h %h %h exp %h %h %h %h", n, k,
                             obs_sv[k], obs_sa[k], obs_rix[k], obs_wix[k], esv, esa, erix, ewix);
        end
      end
      checks++;
      if ({index, entryhi, entrylo0, entrylo1} !== {exp_index, exp_hi, exp_lo0, exp_lo1}) begin
        errors++; $display("FAIL b2b_results[%0d] got %h %h %h %h exp %h %h %h %h", n, index, entryhi,
                           entrylo0, entrylo1, exp_index, exp_hi, exp_lo0, exp_lo1);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    op_valid = 1'b1; op_code = 2'b10; op_pc = 32'h1234_5678; index_index = 4'd3; cp0_wr_pending = 1'b0;
    @(posedge clk); #1; op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tlbr_we, flush} !== 2'b00) begin
      errors++; $display("FAIL rst_commit_pulses got %b exp 00", {tlbr_we, flush});
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({tlb_we, tlbp_we, tlbr_we, flush, op_ready, busy} !== 6'b000010) begin
      errors++; $display("FAIL rst_after_ctl got %b exp 000010", {tlb_we, tlbp_we, tlbr_we, flush, op_ready, busy});
    end
    checks++;
    if ({index, entryhi, entrylo0, entrylo1, flush_pc} !== 160'd0) begin
      errors++; $display("FAIL rst_after_regs got %h %h %h %h %h exp all 0", index, entryhi, entrylo0, entrylo1, flush_pc);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({tlbr_we, flush} !== 2'b00) begin
      errors++; $display("FAIL rst_late_pulses got %b exp 00", {tlbr_we, flush});
    end
    op_valid = 1'b1; op_code = 2'b00; op_pc = 32'h0;
    @(posedge clk); #1; op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({op_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL rst_noop_busy got %b exp 10", {op_ready, busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_pc = 32'h0; cp0_wr_pending = 1'b0;
    entryhi_vpn2 = '0; entryhi_asid = '0; index_index = '0; pre_en = 1'b0; pre_idx = '0;
    pre_hi = '0; pre_lo0 = '0; pre_lo1 = '0; cp0_lo0 = '0; cp0_lo1 = '0;
    exp_index = '0; exp_hi = '0; exp_lo0 = '0; exp_lo1 = '0;
    for (int i = 0; i < TLBNUM; i++)
      set_entry(IDXW'(i), {19'h4_0000 + 19'(i), 5'b0, 8'h80 + 8'(i)}, 32'h100 + 32'(i), 32'h200 + 32'(i));
    test_reset();
    @(posedge clk); #1; reset = 1'b0;
    test_tlbp_hit();
    test_tlbp_miss();
    test_tlbr();
    test_tlbwi();
    test_mtc0_hazard();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
